// File: rtl/mux_index_serializer.sv
// Parallel-in/serial-out sequencer: holds a word on the mux data bus and walks
// the select index across it, one bit per downstream-accepted beat.
module mux_index_serializer #(
  parameter  int WIDTH      = 16,
  parameter  int MSB_FIRST  = 0,
  parameter  int GAP_CYCLES = 0,
  localparam int IDX_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] mux_data,
  output logic [IDX_W-1:0] mux_sel,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic [7:0]       word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] START_IDX = (MSB_FIRST != 0) ? IDX_W'(WIDTH - 1) : {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] END_IDX   = (MSB_FIRST != 0) ? {IDX_W{1'b0}} : IDX_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mux_data_q, mux_data_d;
  logic [IDX_W-1:0] mux_sel_q, mux_sel_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;
  logic [7:0]       word_count_q, word_count_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

  function automatic logic pick_bit(input logic [WIDTH-1:0] word, input logic [IDX_W-1:0] idx);
    return word[idx];
  endfunction

  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx);
    return (MSB_FIRST != 0) ? (idx - IDX_W'(1'b1)) : (idx + IDX_W'(1'b1));
  endfunction

  assign in_ready = (state_q == IDLE) && !rst;

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d      = state_q;
    mux_data_d   = mux_data_q;
    mux_sel_d    = mux_sel_q;
    word_count_d = word_count_q;
    gap_cnt_d    = gap_cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mux_data_d = in_data;
          mux_sel_d  = START_IDX;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (mux_sel_q == END_IDX) begin
            word_count_d = word_count_q + 8'd1;
            if (GAP_CYCLES > 0) begin
              state_d   = GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            mux_sel_d = step_idx(mux_sel_q);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Serial outputs are derived from the next index so they register alongside it
    ser_valid_d = (state_d == SHIFT);
    if (ser_valid_d) begin
      ser_bit_d   = pick_bit(mux_data_d, mux_sel_d);
      ser_first_d = (mux_sel_d == START_IDX);
      ser_last_d  = (mux_sel_d == END_IDX);
    end else begin
      ser_bit_d   = 1'b0;
      ser_first_d = 1'b0;
      ser_last_d  = 1'b0;
    end
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mux_data_q   <= {WIDTH{1'b0}};
      mux_sel_q    <= {IDX_W{1'b0}};
      ser_bit_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_first_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      word_count_q <= 8'd0;
      gap_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      mux_data_q   <= mux_data_d;
      mux_sel_q    <= mux_sel_d;
      ser_bit_q    <= ser_bit_d;
      ser_valid_q  <= ser_valid_d;
      ser_first_q  <= ser_first_d;
      ser_last_q   <= ser_last_d;
      word_count_q <= word_count_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign mux_data   = mux_data_q;
  assign mux_sel    = mux_sel_q;
  assign ser_bit    = ser_bit_q;
  assign ser_valid  = ser_valid_q;
  assign ser_first  = ser_first_q;
  assign ser_last   = ser_last_q;
  assign word_count = word_count_q;

endmodule
